// File: rtl/neander_alu_ctrl.sv
// NEANDER-X ALU sequencing controller.
// Accepts one ALU operation per request over valid/ready and drives the ALU
// opcode and carry-in. For DIV/MOD it starts the external divider and waits
// for it, with a timeout. It issues the AC/Y write enables and owns C/Z/N.
module neander_alu_ctrl #(
   parameter int unsigned DIV_TIMEOUT = 15   // legal range 9..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic [3:0] req_op_i,
   input  logic       abort_i,
   output logic [3:0] alu_op_o,
   output logic       alu_carry_in_o,
   input  logic [7:0] alu_result_i,
   input  logic [7:0] alu_mul_high_i,
   input  logic       alu_carry_out_i,
   output logic       div_start_o,
   input  logic       div_done_i,
   output logic       ac_we_o,
   output logic [7:0] ac_wdata_o,
   output logic       y_we_o,
   output logic [7:0] y_wdata_o,
   output logic       flag_c_o,
   output logic       flag_z_o,
   output logic       flag_n_o,
   output logic       done_o,
   output logic       err_o,
   output logic       busy_o
);

   // ALU opcode map
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b0111;
   localparam logic [3:0] OP_NEG = 4'b1000;
   localparam logic [3:0] OP_MUL = 4'b1001;
   localparam logic [3:0] OP_DIV = 4'b1010;
   localparam logic [3:0] OP_MOD = 4'b1011;
   localparam logic [3:0] OP_ADC = 4'b1100;
   localparam logic [3:0] OP_SBC = 4'b1101;
   localparam logic [3:0] OP_ASR = 4'b1110;
   localparam logic [3:0] OP_ILL = 4'b1111;

   localparam logic [7:0] TMO_LAST = 8'(DIV_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_EXEC      = 2'd1,
      S_DIV_START = 2'd2,
      S_DIV_WAIT  = 2'd3
   } state_e;

   state_e     state_q;
   logic [3:0] alu_op_q;
   logic [7:0] cnt_q;
   logic       flag_c_q, flag_z_q, flag_n_q;

   logic accept, exec_act, wait_act, wb_exec, wb_div, tmo, carry_op;

   // Handshake, writeback and retirement decode; abort masks every effect
   always_comb begin
      req_ready_o = (state_q == S_IDLE) && !abort_i;
      accept      = req_valid_i && req_ready_o;
      exec_act    = (state_q == S_EXEC) && !abort_i;
      wait_act    = (state_q == S_DIV_WAIT) && !abort_i;
      wb_exec     = exec_act && (alu_op_q != OP_ILL);
      wb_div      = wait_act && div_done_i;
      // div_done has priority over the timeout in the same cycle
      tmo         = wait_act && !div_done_i && (cnt_q == TMO_LAST);
      carry_op    = !((alu_op_q == OP_AND) || (alu_op_q == OP_OR) ||
                      (alu_op_q == OP_XOR) || (alu_op_q == OP_NOT));
      ac_we_o     = wb_exec || wb_div;
      y_we_o      = (wb_exec && (alu_op_q == OP_MUL)) || wb_div;
      done_o      = exec_act || wb_div || tmo;
      err_o       = (exec_act && (alu_op_q == OP_ILL)) || tmo;
      div_start_o = (state_q == S_DIV_START);
      busy_o      = (state_q != S_IDLE);
   end

   assign alu_op_o       = alu_op_q;
   assign alu_carry_in_o = flag_c_q;
   assign ac_wdata_o     = alu_result_i;
   assign y_wdata_o      = alu_mul_high_i;
   assign flag_c_o       = flag_c_q;
   assign flag_z_o       = flag_z_q;
   assign flag_n_o       = flag_n_q;

   // Sequencer state, latched opcode, divider timeout counter and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         alu_op_q <= 4'b0000;
         cnt_q    <= 8'd0;
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  alu_op_q <= req_op_i;
                  if ((req_op_i == OP_DIV) || (req_op_i == OP_MOD))
                     state_q <= S_DIV_START;
                  else
                     state_q <= S_EXEC;
               end
            end
            S_EXEC: state_q <= S_IDLE;
            S_DIV_START: begin
               cnt_q   <= 8'd0;
               state_q <= abort_i ? S_IDLE : S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
               cnt_q <= cnt_q + 8'd1;
               if (abort_i || wb_div || tmo)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // Flags change only on the edge closing a writeback or timeout
         if (ac_we_o) begin
            flag_z_q <= (alu_result_i == 8'h00);
            flag_n_q <= alu_result_i[7];
            if (carry_op)
               flag_c_q <= alu_carry_out_i;
         end
         if (tmo)
            flag_c_q <= 1'b1;
      end
   end

   // Opcodes named only for documentation of the map
   logic unused_ops;
   assign unused_ops = ^{OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_NEG, OP_ADC,
                         OP_SBC, OP_ASR};

endmodule

// File: tb/tb_neander_alu_ctrl.sv
// Directed bench for neander_alu_ctrl: inputs driven on the falling edge,
// outputs checked 1 time unit later.
module tb_neander_alu_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready, abort;
   logic [3:0] req_op, alu_op;
   logic       alu_carry_in, alu_carry_out;
   logic [7:0] alu_result, alu_mul_high, ac_wdata, y_wdata;
   logic       div_start, div_done, ac_we, y_we;
   logic       flag_c, flag_z, flag_n, done, err, busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   neander_alu_ctrl #(.DIV_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .abort_i(abort), .alu_op_o(alu_op), .alu_carry_in_o(alu_carry_in),
      .alu_result_i(alu_result), .alu_mul_high_i(alu_mul_high),
      .alu_carry_out_i(alu_carry_out), .div_start_o(div_start),
      .div_done_i(div_done), .ac_we_o(ac_we), .ac_wdata_o(ac_wdata),
      .y_we_o(y_we), .y_wdata_o(y_wdata), .flag_c_o(flag_c),
      .flag_z_o(flag_z), .flag_n_o(flag_n), .done_o(done), .err_o(err),
      .busy_o(busy)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic flags(input string tag, input logic c, input logic z, input logic n);
      chk1({tag, "_C"}, flag_c, c);
      chk1({tag, "_Z"}, flag_z, z);
      chk1({tag, "_N"}, flag_n, n);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Present a request in IDLE; it is accepted on the next rising edge
   task automatic issue(input logic [3:0] op);
      step();
      req_valid = 1'b1;
      req_op    = op;
      #1;
      chk1("issue_ready", req_ready, 1'b1);
   endtask

   initial begin
      int bsy, rdy, ds, dn;
      rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; abort = 1'b0;
      alu_result = 8'h00; alu_mul_high = 8'h00; alu_carry_out = 1'b0;
      div_done = 1'b0;

      // Reset state
      #1;
      chk1("rst_busy", busy, 1'b0);
      chk8("rst_op", {4'h0, alu_op}, 8'h00);
      flags("rst", 1'b0, 1'b0, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_acwe", ac_we, 1'b0);
      chk1("rst_dstart", div_start, 1'b0);
      step(); step();
      rst_n = 1'b1;
      #1;
      chk1("rst_ready", req_ready, 1'b1);

      // 1: ADD 0xF0+0x20 -> 0x10, carry 1
      issue(4'b0000);
      step(); req_valid = 1'b0;
      alu_result = 8'h10; alu_carry_out = 1'b1; #1;
      chk1("add_acwe", ac_we, 1'b1);
      chk8("add_wdata", ac_wdata, 8'h10);
      chk1("add_ywe", y_we, 1'b0);
      chk1("add_done", done, 1'b1);
      chk1("add_err", err, 1'b0);
      chk1("add_ready", req_ready, 1'b0);
      step(); #1;
      flags("add", 1'b1, 1'b0, 1'b0);
      chk1("add_done_off", done, 1'b0);

      // 2: AND -> 0x00 keeps C; then ADC sees carry-in 1
      issue(4'b0010);
      step(); req_valid = 1'b0;
      alu_result = 8'h00; alu_carry_out = 1'b0; #1;
      chk1("and_acwe", ac_we, 1'b1);
      issue(4'b1100);
      flags("and", 1'b1, 1'b1, 1'b0);
      step(); req_valid = 1'b0;
      alu_result = 8'h80; alu_carry_out = 1'b0; #1;
      chk1("adc_cin", alu_carry_in, 1'b1);
      chk8("adc_op", {4'h0, alu_op}, 8'h0C);
      step(); #1;
      flags("adc", 1'b0, 1'b0, 1'b1);

      // 3: MUL 0x10*0x20 -> low 0x00, high 0x02, carry 1
      issue(4'b1001);
      step(); req_valid = 1'b0;
      alu_result = 8'h00; alu_mul_high = 8'h02; alu_carry_out = 1'b1; #1;
      chk1("mul_acwe", ac_we, 1'b1);
      chk1("mul_ywe", y_we, 1'b1);
      chk8("mul_ywdata", y_wdata, 8'h02);
      step(); #1;
      flags("mul", 1'b1, 1'b1, 1'b0);

      // div_done in IDLE is ignored
      step(); div_done = 1'b1; #1;
      chk1("idle_dd_acwe", ac_we, 1'b0);
      chk1("idle_dd_done", done, 1'b0);
      step(); div_done = 1'b0;

      // 4: DIV, div_done on the 9th DIV_WAIT cycle (10 busy cycles)
      issue(4'b1010);
      bsy = 0; rdy = 0; ds = 0;
      for (int k = 1; k <= 10; k++) begin
         step(); req_valid = 1'b0;
         div_done = (k == 10);
         alu_result = 8'h07; alu_mul_high = 8'h03; alu_carry_out = 1'b0; #1;
         if (busy) bsy++;
         if (req_ready) rdy++;
         if (div_start) ds++;
         if (k == 1) chk1("div_start_k1", div_start, 1'b1);
         if (k == 10) begin
            chk1("div_acwe", ac_we, 1'b1);
            chk1("div_ywe", y_we, 1'b1);
            chk8("div_ac", ac_wdata, 8'h07);
            chk8("div_y", y_wdata, 8'h03);
            chk1("div_done", done, 1'b1);
            chk1("div_err", err, 1'b0);
         end
      end
      step(); div_done = 1'b0; #1;
      chki("div_busy_cycles", bsy, 10);
      chki("div_ready_cycles", rdy, 0);
      chki("div_start_cycles", ds, 1);
      chk1("div_idle", busy, 1'b0);
      flags("div", 1'b0, 1'b0, 1'b0);

      // 5a: DIV timeout after 15 DIV_WAIT cycles
      issue(4'b1010);
      dn = 0;
      for (int k = 1; k <= 16; k++) begin
         step(); req_valid = 1'b0;
         alu_result = 8'h00; alu_carry_out = 1'b0; #1;
         if (k < 16 && done) dn++;
         if (k == 16) begin
            chk1("tmo_done", done, 1'b1);
            chk1("tmo_err", err, 1'b1);
            chk1("tmo_acwe", ac_we, 1'b0);
            chk1("tmo_ywe", y_we, 1'b0);
         end
      end
      chki("tmo_early_done", dn, 0);
      step(); #1;
      chk1("tmo_idle", busy, 1'b0);
      flags("tmo", 1'b1, 1'b0, 1'b0);

      // 5b: illegal opcode
      issue(4'b1111);
      step(); req_valid = 1'b0;
      alu_result = 8'h00; alu_carry_out = 1'b0; #1;
      chk1("ill_done", done, 1'b1);
      chk1("ill_err", err, 1'b1);
      chk1("ill_acwe", ac_we, 1'b0);
      step(); #1;
      flags("ill", 1'b1, 1'b0, 1'b0);

      // div_done in the timeout cycle wins
      issue(4'b1010);
      for (int k = 1; k <= 16; k++) begin
         step(); req_valid = 1'b0;
         div_done = (k == 16);
         alu_result = 8'h85; alu_mul_high = 8'h01; alu_carry_out = 1'b0; #1;
         if (k == 16) begin
            chk1("race_acwe", ac_we, 1'b1);
            chk1("race_err", err, 1'b0);
         end
      end
      step(); div_done = 1'b0; #1;
      flags("race", 1'b0, 1'b0, 1'b1);

      // 6a: abort in DIV_WAIT cycle 3, alongside div_done
      issue(4'b1010);
      for (int k = 1; k <= 4; k++) begin
         step(); req_valid = 1'b0;
         abort = (k == 4); div_done = (k == 4);
         alu_result = 8'h00; alu_carry_out = 1'b1; #1;
         if (k == 4) begin
            chk1("abort_acwe", ac_we, 1'b0);
            chk1("abort_ywe", y_we, 1'b0);
            chk1("abort_done", done, 1'b0);
            chk1("abort_err", err, 1'b0);
         end
      end
      step(); abort = 1'b0; div_done = 1'b0; #1;
      chk1("abort_idle", busy, 1'b0);
      flags("abort", 1'b0, 1'b0, 1'b1);

      // abort in IDLE blocks acceptance
      step(); req_valid = 1'b1; req_op = 4'b0000; abort = 1'b1; #1;
      chk1("abort_idle_ready", req_ready, 1'b0);
      step(); req_valid = 1'b0; abort = 1'b0; #1;
      chk1("abort_idle_noacc", busy, 1'b0);

      // 6b: async reset mid-DIV, then a late div_done
      issue(4'b1010);
      step(); req_valid = 1'b0;
      step(); step(); #1;
      chk1("pre_rst_busy", busy, 1'b1);
      rst_n = 1'b0; #1;
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_dstart", div_start, 1'b0);
      chk8("arst_op", {4'h0, alu_op}, 8'h00);
      flags("arst", 1'b0, 1'b0, 1'b0);
      step(); rst_n = 1'b1; div_done = 1'b1; alu_result = 8'h55; #1;
      chk1("late_dd_acwe", ac_we, 1'b0);
      chk1("late_dd_done", done, 1'b0);
      step(); #1;
      chk1("late_dd_busy", busy, 1'b0);
      div_done = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
